riscv_issue_queue: RTL and testbench
====================================

# riscv_issue_queue

Parametrised instruction buffer and in-order issue stage placed between the instruction source and `riscv_top`. It accepts 32-bit RV32I instruction words over a valid/ready handshake, holds up to DEPTH of them in a circular FIFO, and issues them in order. A per-register scoreboard stalls the head instruction until any register it reads has been written back by an earlier in-flight instruction, which lets dependent sequences stream in without hand-inserted gaps.

## Interface
- WIDTH, 32, instruction word width; must be ≥ 32 because decode uses bits [31:0].
- DEPTH, 4, FIFO entries; a power of two, ≥ 2.
- LATENCY, 3, issue-to-writeback distance in cycles; ≥ 1.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-low (0 = reset).
- flush  input  1  synchronous queue clear.
- in_valid  input  1  in_instr is offered.
- in_ready  output  1  queue can accept an entry.
- in_instr  input  WIDTH  instruction word.
- out_valid  output  1  head entry is issuable.
- out_ready  input  1  downstream accepts.
- out_instr  output  WIDTH  head entry.
- stall  output  1  queue is non-empty but the head is blocked by a hazard.
- count  output  $clog2(DEPTH+1)  occupancy.

## Operation
- Storage: DEPTH×WIDTH array with wr_ptr and rd_ptr, each $clog2(DEPTH) bits. Pointers wrap modulo DEPTH. A separate count register tracks occupancy.
- Push happens when in_valid && in_ready, with in_ready = (count != DEPTH). There is no pass-through: when full, in_ready stays 0 even if a pop happens in the same cycle.
- Pop happens when out_valid && out_ready.
- If a push and a pop occur in the same cycle, count is unchanged and both pointers advance.
- Decode of the head word uses opcode [6:0], rd [11:7], rs1 [19:15] and rs2 [24:20].
  - Writes rd: opcodes 0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111.
  - Reads rs1: opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
  - Reads rs2: opcodes 0110011, 0100011, 1100011.
  - Any other opcode reads and writes nothing and issues without checks.
- Scoreboard: 31 down-counters, one per register x1–x31, each $clog2(LATENCY) bits wide (minimum 1).
  - busy[r] = (ctr[r] != 0). x0 is never busy and is never loaded.
  - When an instruction that writes rd ≠ 0 issues, ctr[rd] loads LATENCY-1.
  - Every other nonzero counter decrements by 1 each cycle.
  - If a load and a decrement target the same register in one cycle, the load wins.
- hazard = (reads rs1 && busy[rs1]) || (reads rs2 && busy[rs2]).
- out_valid = (count != 0) && !hazard.
- stall = (count != 0) && hazard.
- out_instr = mem[rd_ptr], regardless of out_valid.
- flush: at the next edge, pointers and count go to 0 and any push in that cycle is dropped. The scoreboard is NOT cleared, because issued instructions still write back.
- Reset (rst = 0): immediately clears pointers, count and all scoreboard counters, including mid-stream. Array contents are don't-care.

## Timing
- Reset values: in_ready = 1, out_valid = 0, stall = 0, count = 0. out_instr is undefined (array not reset).
- Fill latency: a word pushed at edge t is visible on out_instr, with out_valid asserted if it has no hazard, from edge t onward; it can issue at edge t+1.
- Throughput: one push and one pop per cycle.
- Dependency rule: a consumer issues no earlier than LATENCY edges after its producer's issue edge. With LATENCY = 1, dependent instructions issue back-to-back.
- All outputs are combinational functions of registered state only. There are no combinational in→out paths except in_ready, which depends only on count.
- out_valid may drop without out_ready having been asserted, but only on flush or reset. Otherwise, once out_valid is asserted, the head entry and out_valid hold until they are popped.

## Test plan
- **Reset and fill:** hold rst = 0 for 2 cycles, then push 4 words with out_ready = 0.
  - After reset: count = 0, in_ready = 1, out_valid = 0.
  - After the 4 pushes: count = 4, in_ready = 0, and a 5th in_valid is not accepted.
  - Popping then returns the words in order.
- **RAW stall, LATENCY = 3, out_ready = 1:** push 00A08093 (ADDI x1), 00A10113 (ADDI x2), 001101B3 (ADD x3,x2,x1) back-to-back.
  - The ADDIs issue on consecutive edges e and e+1.
  - ADD holds stall = 1 and issues at edge e+4.
- **Back-to-back with no hazard, LATENCY = 1:** the same three words issue on three consecutive edges, and stall stays 0.
- **Wrap-around:** with DEPTH = 4, stream 10 words with simultaneous push and pop each cycle.
  - count stays constant.
  - Output order equals input order across pointer wrap.
- **x0 and non-reading ops:** ADDI x0,x0,1 (00100013) followed by ADD x5,x0,x0 (000002B3) gives no stall. A LUI after a busy register gives no stall.
- **Flush and async reset:** flush with 3 entries plus a simultaneous push.
  - Next cycle: count = 0, and a pending hazard counter still blocks a later dependent instruction.
  - Asserting rst mid-cycle clears count and stall immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/riscv_issue_queue.sv
// riscv_issue_queue: circular instruction FIFO with in-order issue.
// The head instruction waits while any source register it reads still has
// an outstanding write from an earlier issued instruction. Each register
// x1..x31 has a small down-counter that holds the remaining writeback time.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready depends only on occupancy. out_valid depends only on
// registered state. Once out_valid is high, it and out_instr hold until the
// entry pops; the only exceptions are flush and reset.
module riscv_issue_queue #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_instr,
    output logic                       stall,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [SW-1:0] LOAD_VAL   = SW'(LATENCY - 1);

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;

    logic [SW-1:0]    ctr [1:31];
    logic [31:0]      busy;

    logic [6:0]       opc;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             wr_rd;
    logic             rd_rs1;
    logic             rd_rs2;
    logic             hazard;
    logic             not_empty;
    logic             push;
    logic             pop;
    logic             issue_wr;

    assign not_empty = (count_q != '0);
    assign in_ready  = (count_q != FULL_COUNT);
    assign out_instr = mem[rd_ptr];
    assign count     = count_q;

    // Decode the head word: which registers it reads and whether it writes rd.
    always_comb begin
        opc    = out_instr[6:0];
        rd     = out_instr[11:7];
        rs1    = out_instr[19:15];
        rs2    = out_instr[24:20];
        wr_rd  = 1'b0;
        rd_rs1 = 1'b0;
        rd_rs2 = 1'b0;
        case (opc)
            OP_REG: begin
                wr_rd  = 1'b1;
                rd_rs1 = 1'b1;
                rd_rs2 = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                wr_rd  = 1'b1;
                rd_rs1 = 1'b1;
            end
            OP_STORE, OP_BRANCH: begin
                rd_rs1 = 1'b1;
                rd_rs2 = 1'b1;
            end
            OP_LUI, OP_AUIPC, OP_JAL: begin
                wr_rd  = 1'b1;
            end
            default: begin
                wr_rd  = 1'b0;
            end
        endcase
    end

    // Busy view of the scoreboard; x0 is hardwired not busy.
    always_comb begin
        busy = '0;
        for (int r = 1; r < 32; r++) begin
            busy[r] = (ctr[r] != '0);
        end
    end

    assign hazard    = (rd_rs1 && busy[rs1]) || (rd_rs2 && busy[rs2]);
    assign out_valid = not_empty && !hazard;
    assign stall     = not_empty && hazard;

    // Flush drops a same-cycle push, but an issue in that cycle still counts.
    assign push     = in_valid && in_ready && !flush;
    assign pop      = out_valid && out_ready;
    assign issue_wr = pop && wr_rd && (rd != 5'd0);

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_instr;
        end
    end

    // Pointer and occupancy bookkeeping with synchronous flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Writeback countdown per register; a new issue reloads over the decrement.
    // Flush leaves this alone because issued instructions still complete.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 1; r < 32; r++) begin
                ctr[r] <= '0;
            end
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (issue_wr && (rd == 5'(r))) begin
                    ctr[r] <= LOAD_VAL;
                end else if (ctr[r] != '0) begin
                    ctr[r] <= ctr[r] - SW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_issue_queue.sv
// Directed testbench for riscv_issue_queue. dut0 runs with LATENCY = 3 and
// dut1 with LATENCY = 1; both share clock and reset.
module tb_riscv_issue_queue;

    localparam int W  = 32;
    localparam int CW = 3;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- dut0 (LATENCY = 3) ----------------
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_instr;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_instr;
    logic          stall;
    logic [CW-1:0] count;

    riscv_issue_queue #(.WIDTH(W), .DEPTH(4), .LATENCY(3)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .stall     (stall),
        .count     (count)
    );

    // ---------------- dut1 (LATENCY = 1) ----------------
    logic          flush1;
    logic          in_valid1;
    logic          in_ready1;
    logic [W-1:0]  in_instr1;
    logic          out_valid1;
    logic          out_ready1;
    logic [W-1:0]  out_instr1;
    logic          stall1;
    logic [CW-1:0] count1;

    riscv_issue_queue #(.WIDTH(W), .DEPTH(4), .LATENCY(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush1),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_instr  (in_instr1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_instr (out_instr1),
        .stall     (stall1),
        .count     (count1)
    );

    // ---------------- scoreboard state ----------------
    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_q[$];

    localparam logic [W-1:0] I_ADDI_X1  = 32'h00A08093;
    localparam logic [W-1:0] I_ADDI_X2  = 32'h00A10113;
    localparam logic [W-1:0] I_ADD_X3   = 32'h001101B3; // add x3,x2,x1
    localparam logic [W-1:0] I_ADD_X311 = 32'h001081B3; // add x3,x1,x1
    localparam logic [W-1:0] I_ADDI_X0  = 32'h00100013;
    localparam logic [W-1:0] I_ADD_X5   = 32'h000002B3;
    localparam logic [W-1:0] I_LUI_X6   = 32'h00009337; // rs1 field = x1

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b0;
        flush1    = 1'b0;
        in_valid1 = 1'b0;
        in_instr1 = '0;
        out_ready1 = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        step();
        step();
        tests++;
        if (count !== 3'd0) begin
            fails++;
            $display("FAIL reset_count: got %0d expected 0", count);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        tests++;
        if (out_valid !== 1'b0 || stall !== 1'b0) begin
            fails++;
            $display("FAIL reset_out_valid_stall: got %b/%b expected 0/0", out_valid, stall);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_fill();
        exp_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_instr = 32'hF000_0000 | W'(i << 12);
            exp_q.push_back(in_instr);
            step();
        end
        tests++;
        if (count !== 3'd4) begin
            fails++;
            $display("FAIL fill_count: got %0d expected 4", count);
        end
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL fill_in_ready: got %b expected 0", in_ready);
        end
        // fifth word offered while full and nothing pops
        in_instr = 32'hDEAD_0000;
        step();
        tests++;
        if (count !== 3'd4) begin
            fails++;
            $display("FAIL fill_fifth_rejected: got count %0d expected 4", count);
        end
        // keep offering while popping: no pass-through when full
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (out_valid !== 1'b1 || out_instr !== exp_q[0]) begin
                fails++;
                $display("FAIL fill_pop_order[%0d]: got %b/%h expected 1/%h", i, out_valid, out_instr, exp_q[0]);
            end
            void'(exp_q.pop_front());
            step();
            in_valid = 1'b0;
            tests++;
            if (count !== CW'(exp_q.size())) begin
                fails++;
                $display("FAIL fill_pop_count[%0d]: got %0d expected %0d", i, count, exp_q.size());
            end
        end
        idle_inputs();
    endtask

    task automatic test_raw_stall();
        logic [W-1:0] prog [3];
        int issue_at[$];
        logic [W-1:0] issued[$];
        int stalls;
        prog[0] = I_ADDI_X1;
        prog[1] = I_ADDI_X2;
        prog[2] = I_ADD_X3;
        stalls = 0;
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c < 3);
            if (c < 3) in_instr = prog[c];
            else       in_instr = '0;
            if (out_valid && out_ready) begin
                issue_at.push_back(c);
                issued.push_back(out_instr);
            end
            if (stall) stalls++;
            step();
        end
        idle_inputs();
        tests++;
        if (issue_at.size() != 3) begin
            fails++;
            $display("FAIL raw_issue_count: got %0d expected 3", issue_at.size());
        end else begin
            tests++;
            if (issue_at[0] != 1 || issue_at[1] != 2 || issue_at[2] != 5) begin
                fails++;
                $display("FAIL raw_issue_edges: got %0d,%0d,%0d expected 1,2,5", issue_at[0], issue_at[1], issue_at[2]);
            end
            tests++;
            if (issued[0] !== prog[0] || issued[1] !== prog[1] || issued[2] !== prog[2]) begin
                fails++;
                $display("FAIL raw_issue_order: got %h,%h,%h", issued[0], issued[1], issued[2]);
            end
        end
        tests++;
        if (stalls != 2) begin
            fails++;
            $display("FAIL raw_stall_cycles: got %0d expected 2", stalls);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] prog [3];
        int issue_at[$];
        int stalls;
        prog[0] = I_ADDI_X1;
        prog[1] = I_ADDI_X2;
        prog[2] = I_ADD_X3;
        stalls = 0;
        do_reset();
        out_ready1 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_valid1 = (c < 3);
            if (c < 3) in_instr1 = prog[c];
            else       in_instr1 = '0;
            if (out_valid1 && out_ready1) issue_at.push_back(c);
            if (stall1) stalls++;
            step();
        end
        idle_inputs();
        tests++;
        if (issue_at.size() != 3) begin
            fails++;
            $display("FAIL b2b_issue_count: got %0d expected 3", issue_at.size());
        end else begin
            tests++;
            if (issue_at[0] != 1 || issue_at[1] != 2 || issue_at[2] != 3) begin
                fails++;
                $display("FAIL b2b_issue_edges: got %0d,%0d,%0d expected 1,2,3", issue_at[0], issue_at[1], issue_at[2]);
            end
        end
        tests++;
        if (stalls != 0) begin
            fails++;
            $display("FAIL b2b_stall_cycles: got %0d expected 0", stalls);
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] w;
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_instr = 32'hC0DE_0000 | W'(i << 8);
            exp_q.push_back(in_instr);
            step();
        end
        out_ready = 1'b1;
        for (int i = 2; i < 12; i++) begin
            w = 32'hC0DE_0000 | W'(i << 8);
            in_valid = 1'b1;
            in_instr = w;
            tests++;
            if (out_valid !== 1'b1 || out_instr !== exp_q[0]) begin
                fails++;
                $display("FAIL wrap_order[%0d]: got %b/%h expected 1/%h", i, out_valid, out_instr, exp_q[0]);
            end
            void'(exp_q.pop_front());
            exp_q.push_back(w);
            step();
            tests++;
            if (count !== 3'd2) begin
                fails++;
                $display("FAIL wrap_count[%0d]: got %0d expected 2", i, count);
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tests++;
            if (out_valid !== 1'b1 || out_instr !== exp_q[0]) begin
                fails++;
                $display("FAIL wrap_drain[%0d]: got %b/%h expected 1/%h", i, out_valid, out_instr, exp_q[0]);
            end
            void'(exp_q.pop_front());
            step();
        end
        tests++;
        if (count !== 3'd0) begin
            fails++;
            $display("FAIL wrap_empty: got %0d expected 0", count);
        end
        idle_inputs();
    endtask

    task automatic test_x0_and_lui();
        logic [W-1:0] prog [4];
        int issue_at[$];
        int stalls;
        prog[0] = I_ADDI_X0;
        prog[1] = I_ADD_X5;
        prog[2] = I_ADDI_X1;
        prog[3] = I_LUI_X6;
        stalls = 0;
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_valid = (c < 4);
            if (c < 4) in_instr = prog[c];
            else       in_instr = '0;
            if (out_valid && out_ready) issue_at.push_back(c);
            if (stall) stalls++;
            step();
        end
        idle_inputs();
        tests++;
        if (stalls != 0) begin
            fails++;
            $display("FAIL x0_lui_stall_cycles: got %0d expected 0", stalls);
        end
        tests++;
        if (issue_at.size() != 4) begin
            fails++;
            $display("FAIL x0_lui_issue_count: got %0d expected 4", issue_at.size());
        end else begin
            tests++;
            if (issue_at[0] != 1 || issue_at[1] != 2 || issue_at[2] != 3 || issue_at[3] != 4) begin
                fails++;
                $display("FAIL x0_lui_issue_edges: got %0d,%0d,%0d,%0d expected 1,2,3,4",
                         issue_at[0], issue_at[1], issue_at[2], issue_at[3]);
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = I_ADDI_X1;
        step();
        in_instr  = 32'h0000_1000;
        step();
        in_instr  = 32'h0000_2000;
        step();
        tests++;
        if (count !== 3'd3) begin
            fails++;
            $display("FAIL flush_prefill: got %0d expected 3", count);
        end
        // flush with a simultaneous push; the head ADDI x1 issues this edge
        flush     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h1234_5000;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        tests++;
        if (count !== 3'd0 || out_valid !== 1'b0 || stall !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_clear: got count %0d ov %b st %b ir %b expected 0 0 0 1",
                     count, out_valid, stall, in_ready);
        end
        // dependent on x1 still blocked by the surviving scoreboard
        in_valid = 1'b1;
        in_instr = I_ADD_X311;
        step();
        in_valid = 1'b0;
        tests++;
        if (count !== 3'd1 || stall !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_hazard_kept: got count %0d st %b ov %b expected 1 1 0", count, stall, out_valid);
        end
        step();
        tests++;
        if (stall !== 1'b0 || out_valid !== 1'b1 || out_instr !== I_ADD_X311) begin
            fails++;
            $display("FAIL flush_hazard_release: got st %b ov %b %h expected 0 1 %h",
                     stall, out_valid, out_instr, I_ADD_X311);
        end
        step();
        tests++;
        if (count !== 3'd0) begin
            fails++;
            $display("FAIL flush_final_pop: got %0d expected 0", count);
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = I_ADDI_X1;
        step();
        in_instr  = I_ADD_X311;
        step();
        in_valid  = 1'b0;
        tests++;
        if (stall !== 1'b1 || count !== 3'd1) begin
            fails++;
            $display("FAIL async_pre: got st %b count %0d expected 1 1", stall, count);
        end
        #3;
        rst = 1'b0;
        #1;
        tests++;
        if (count !== 3'd0 || stall !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL async_reset: got count %0d st %b ov %b ir %b expected 0 0 0 1",
                     count, stall, out_valid, in_ready);
        end
        step();
        rst = 1'b1;
        idle_inputs();
        step();
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_fill();
        test_raw_stall();
        test_back_to_back();
        test_wrap();
        test_x0_and_lui();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
